// File: rtl/data_bus_arbiter_pkg.sv
// Shared state encodings, requester indices and burst default for the data bus arbiter.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arbState_t;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int ARB_MAX_BURST = 8;

endpackage

// File: rtl/data_bus_arbiter_burst_counter.sv
// Counts consecutive owner beats taken while the other side waits; flags the last allowed beat.
module data_bus_arbiter_burst_counter
  import data_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  logic [7:0] count;

  assign terminal = (count == LAST_BEAT);

  // Holds at the terminal value so a locked owner is handed over on its first unlocked beat.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the single RAM data port: registered ownership, round-robin, lock, bounded bursts.
// Define ARB_STATS_EN to add the saturating wait0Cnt/wait1Cnt cycle counters.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic                we0,
  input  logic                we1,
  input  logic [DATA_W/8-1:0] mask0,
  input  logic [DATA_W/8-1:0] mask1,
  output logic                ack0,
  output logic                ack1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
`ifdef ARB_STATS_EN
  output logic [15:0]         wait0Cnt,
  output logic [15:0]         wait1Cnt,
`endif
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWriteData,
  input  logic [DATA_W-1:0]   memReadData,
  output logic                memWr,
  output logic [DATA_W/8-1:0] wrMask
);

  arbState_t state;
  arbState_t nextState;
  logic      ptr;
  logic      nextPtr;
  logic      ownerReq;
  logic      otherReq;
  logic      burstTc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      ptr   <= REQ_CPU;
    end else begin
      state <= nextState;
      ptr   <= nextPtr;
    end
  end

  always_comb begin
    ownerReq = 1'b0;
    otherReq = 1'b0;
    case (state)
      ARB_OWN0: begin
        ownerReq = req0;
        otherReq = req1;
      end
      ARB_OWN1: begin
        ownerReq = req1;
        otherReq = req0;
      end
      default: ;
    endcase
  end

  // Release with the other side waiting goes straight across; lock beats the burst limit.
  always_comb begin
    nextState = state;
    nextPtr   = ptr;
    case (state)
      ARB_IDLE: begin
        if (req0 && req1) begin
          nextState = (ptr == REQ_LOADER) ? ARB_OWN1 : ARB_OWN0;
        end else if (req0) begin
          nextState = ARB_OWN0;
        end else if (req1) begin
          nextState = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!req0 && !lock0) begin
          nextState = req1 ? ARB_OWN1 : ARB_IDLE;
        end else if (req0 && req1 && !lock0 && burstTc) begin
          nextState = ARB_OWN1;
        end
      end
      ARB_OWN1: begin
        if (!req1 && !lock1) begin
          nextState = req0 ? ARB_OWN0 : ARB_IDLE;
        end else if (req1 && req0 && !lock1 && burstTc) begin
          nextState = ARB_OWN0;
        end
      end
      default: nextState = ARB_IDLE;
    endcase
    if (nextState == ARB_OWN0 && state != ARB_OWN0) begin
      nextPtr = REQ_LOADER;
    end else if (nextState == ARB_OWN1 && state != ARB_OWN1) begin
      nextPtr = REQ_CPU;
    end
  end

  data_bus_arbiter_burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) burstCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    ((nextState != state) || !otherReq),
    .inc      (ownerReq && otherReq),
    .terminal (burstTc)
  );

  // Reset suppresses the in-flight beat without waiting for the state register.
  always_comb begin
    ack0         = 1'b0;
    ack1         = 1'b0;
    memWr        = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    wrMask       = '0;
    if (!reset) begin
      case (state)
        ARB_OWN0: begin
          memAddr      = addr0;
          memWriteData = wdata0;
          wrMask       = mask0;
          memWr        = we0 && req0;
          ack0         = req0;
        end
        ARB_OWN1: begin
          memAddr      = addr1;
          memWriteData = wdata1;
          wrMask       = mask1;
          memWr        = we1 && req1;
          ack1         = req1;
        end
        default: ;
      endcase
    end
  end

  assign rdata0 = ack0 ? memReadData : '0;
  assign rdata1 = ack1 ? memReadData : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait0Cnt <= '0;
      wait1Cnt <= '0;
    end else begin
      if (req0 && !ack0 && wait0Cnt != 16'hFFFF) begin
        wait0Cnt <= wait0Cnt + 16'd1;
      end
      if (req1 && !ack1 && wait1Cnt != 16'hFFFF) begin
        wait1Cnt <= wait1Cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: vector table, directed corner sequences, random vs. reference model.
module tb_data_bus_arbiter;

  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  mask0, mask1;
  logic        ack0, ack1, memWr;
  logic [31:0] rdata0, rdata1, memAddr, memWriteData, memReadData;
  logic [3:0]  wrMask;
`ifdef ARB_STATS_EN
  logic [15:0] wait0Cnt, wait1Cnt;
`endif

  logic [31:0] ram [0:255];
  logic        useRam;
  logic [31:0] rndRdata;

  int assertions = 0;
  int failures   = 0;

  // {r0,r1} {l0,l1} {w0,w1} {expAck0,expAck1,expWr} expSel(0 none,1 addr0,2 addr1)
  typedef struct packed {
    logic       r0, r1, l0, l1, w0, w1;
    logic       eA0, eA1, eWr;
    logic [1:0] eSel;
  } vec_t;

  vec_t vecs [11];
  vec_t v;

  int mOwner, mPtr, mRun;
  int mWait [2];

  always #5 clk = ~clk;

  assign memReadData = useRam ? ram[memAddr[7:0]] : rndRdata;

  always @(posedge clk) begin
    if (memWr) begin
      for (int b = 0; b < 4; b++) begin
        if (wrMask[b]) ram[memAddr[7:0]][b*8 +: 8] <= memWriteData[b*8 +: 8];
      end
    end
  end

  data_bus_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .lock0        (lock0),
    .lock1        (lock1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .we0          (we0),
    .we1          (we1),
    .mask0        (mask0),
    .mask1        (mask1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
`ifdef ARB_STATS_EN
    .wait0Cnt     (wait0Cnt),
    .wait1Cnt     (wait1Cnt),
`endif
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .memWr        (memWr),
    .wrMask       (wrMask)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic l0, input logic l1,
                               input logic w0, input logic w1);
    req0  = r0;
    req1  = r1;
    lock0 = l0;
    lock1 = l1;
    we0   = w0;
    we1   = w1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
  endtask

  // Reference: owner/pointer/run length derived directly from the arbitration rules.
  task automatic checkRandom(input int n);
    logic       eAck [2];
    logic [31:0] eAddr, eData;
    logic [3:0] eMask;
    logic       eWr;
    eAck[0] = !reset && mOwner == 0 && req0;
    eAck[1] = !reset && mOwner == 1 && req1;
    eAddr = 32'h0; eData = 32'h0; eMask = 4'h0; eWr = 1'b0;
    if (!reset && mOwner == 0) begin
      eAddr = addr0; eData = wdata0; eMask = mask0; eWr = we0 && req0;
    end else if (!reset && mOwner == 1) begin
      eAddr = addr1; eData = wdata1; eMask = mask1; eWr = we1 && req1;
    end
    checkOutput($sformatf("rnd%0d.ack0", n), ack0, eAck[0]);
    checkOutput($sformatf("rnd%0d.ack1", n), ack1, eAck[1]);
    checkOutput($sformatf("rnd%0d.memWr", n), memWr, eWr);
    checkOutput($sformatf("rnd%0d.memAddr", n), memAddr, eAddr);
    checkOutput($sformatf("rnd%0d.memWriteData", n), memWriteData, eData);
    checkOutput($sformatf("rnd%0d.wrMask", n), wrMask, eMask);
    checkOutput($sformatf("rnd%0d.rdata0", n), rdata0, eAck[0] ? rndRdata : 32'h0);
    checkOutput($sformatf("rnd%0d.rdata1", n), rdata1, eAck[1] ? rndRdata : 32'h0);
`ifdef ARB_STATS_EN
    checkOutput($sformatf("rnd%0d.wait0Cnt", n), wait0Cnt, mWait[0]);
    checkOutput($sformatf("rnd%0d.wait1Cnt", n), wait1Cnt, mWait[1]);
`endif
  endtask

  task automatic modelStep();
    logic rq [2];
    logic lk [2];
    int   o, oth;
    rq[0] = req0; rq[1] = req1;
    lk[0] = lock0; lk[1] = lock1;
    if (reset) begin
      mOwner = -1; mPtr = 0; mRun = 0; mWait[0] = 0; mWait[1] = 0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (rq[k] && mOwner != k && mWait[k] < 65535) mWait[k]++;
    end
    if (mOwner < 0) begin
      if (rq[0] || rq[1]) begin
        mOwner = (rq[0] && rq[1]) ? mPtr : (rq[0] ? 0 : 1);
        mPtr   = 1 - mOwner;
        mRun   = 0;
      end
    end else begin
      o   = mOwner;
      oth = 1 - o;
      if (!rq[o]) begin
        if (!lk[o]) begin
          mRun = 0;
          if (rq[oth]) begin mOwner = oth; mPtr = o; end
          else mOwner = -1;
        end else if (!rq[oth]) begin
          mRun = 0;
        end
      end else begin
        if (rq[oth]) mRun++;
        else mRun = 0;
        if (mRun >= MAX_BURST && !lk[o]) begin
          mOwner = oth; mPtr = o; mRun = 0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  beats;
    bit  handed;
    int  prob;
    logic [31:0] expAddr;

    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    vecs[0]  = 11'b10_00_10_000_00;
    vecs[1]  = 11'b10_00_10_101_01;
    vecs[2]  = 11'b01_00_01_000_01;
    vecs[3]  = 11'b01_00_00_010_10;
    vecs[4]  = 11'b10_01_00_000_10;
    vecs[5]  = 11'b10_01_00_000_10;
    vecs[6]  = 11'b10_00_00_000_10;
    vecs[7]  = 11'b10_00_00_100_01;
    vecs[8]  = 11'b00_00_00_000_01;
    vecs[9]  = 11'b11_00_00_000_00;
    vecs[10] = 11'b11_00_01_011_10;

    reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0);
    addr0 = 32'hA0; addr1 = 32'hB1;
    wdata0 = 32'h1111_0000; wdata1 = 32'h2222_0000;
    mask0 = 4'h3; mask1 = 4'hC;
    useRam = 1'b0; rndRdata = 32'h5A5A_0001;

    // Reset held two cycles with both requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("resetAck0", ack0, 1'b0);
      checkOutput("resetAck1", ack1, 1'b0);
      checkOutput("resetMemWr", memWr, 1'b0);
      nextCycle();
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleAck0", ack0, 1'b0);
    nextCycle();

    // Continuous contention: exactly MAX_BURST beats for 0, then 1 with no gap
    for (int i = 0; i < MAX_BURST; i++) begin
      @(negedge clk);
      checkOutput($sformatf("burst%0d.ack0", i), ack0, 1'b1);
      checkOutput($sformatf("burst%0d.ack1", i), ack1, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("burstHandover.ack1", ack1, 1'b1);
    checkOutput("burstHandover.ack0", ack0, 1'b0);
    checkOutput("burstHandover.memAddr", memAddr, 32'hB1);
    nextCycle();

    // Owner 1 releases while 0 waits
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("release1.ack1", ack1, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("release1.ack0", ack0, 1'b1);
    checkOutput("release1.memAddr", memAddr, 32'hA0);

    // Reset mid-beat drops the write and returns to IDLE
    we0 = 1'b1;
    #1;
    checkOutput("preReset.memWr", memWr, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("midReset.memWr", memWr, 1'b0);
    checkOutput("midReset.ack0", ack0, 1'b0);
    nextCycle();
    reset = 1'b0;
    addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF; mask0 = 4'hF;
    @(negedge clk);
    checkOutput("postReset.idleAck0", ack0, 1'b0);
    nextCycle();

    // Write then read back through the RAM
    @(negedge clk);
    checkOutput("write.memWr", memWr, 1'b1);
    checkOutput("write.memAddr", memAddr, 32'h10);
    checkOutput("write.ack0", ack0, 1'b1);
    checkOutput("write.wrMask", wrMask, 4'hF);
    checkOutput("write.memWriteData", memWriteData, 32'hDEAD_BEEF);
    nextCycle();
    we0 = 1'b0; useRam = 1'b1;
    @(negedge clk);
    checkOutput("read.memWr", memWr, 1'b0);
    checkOutput("read.rdata0", rdata0, 32'hDEAD_BEEF);
    checkOutput("read.rdata1", rdata1, 32'h0);
    nextCycle();
    useRam = 1'b0;

    // Vector table from a fresh IDLE
    applyStimulus(0, 0, 0, 0, 0, 0);
    addr0 = 32'hA0; mask0 = 4'h3;
    resetCycle();
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      applyStimulus(v.r0, v.r1, v.l0, v.l1, v.w0, v.w1);
      @(negedge clk);
      expAddr = (v.eSel == 2'd1) ? 32'hA0 : ((v.eSel == 2'd2) ? 32'hB1 : 32'h0);
      checkOutput($sformatf("vec%0d.ack0", i), ack0, v.eA0);
      checkOutput($sformatf("vec%0d.ack1", i), ack1, v.eA1);
      checkOutput($sformatf("vec%0d.memWr", i), memWr, v.eWr);
      checkOutput($sformatf("vec%0d.memAddr", i), memAddr, expAddr);
      nextCycle();
    end

    // Lock keeps owner 0 well past MAX_BURST; releasing it hands over promptly
    applyStimulus(1, 1, 1, 0, 0, 0);
    resetCycle();
    nextCycle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lock%0d.ack0", i), ack0, 1'b1);
      checkOutput($sformatf("lock%0d.ack1", i), ack1, 1'b0);
      nextCycle();
    end
    lock0 = 1'b0;
    beats = 0;
    handed = 1'b0;
    for (int i = 0; i < MAX_BURST + 1 && !handed; i++) begin
      @(negedge clk);
      if (ack1) handed = 1'b1;
      else if (ack0) beats++;
      nextCycle();
    end
    checkOutput("lockRelease.handover", {63'h0, handed && beats <= MAX_BURST}, 64'h1);

`ifdef ARB_STATS_EN
    applyStimulus(1, 0, 1, 0, 0, 0);
    resetCycle();
    nextCycle();
    req1 = 1'b1;
    for (int i = 0; i < 5; i++) nextCycle();
    @(negedge clk);
    checkOutput("stats.wait1Cnt", wait1Cnt, 16'd5);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    checkOutput("stats.wait1AfterReset", wait1Cnt, 16'd0);
    reset = 1'b0;
`endif

    // Random traffic against the reference model
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    modelStep();
    nextCycle();
    for (int n = 0; n < 600; n++) begin
      prob   = ((n / 40) % 2 == 1) ? 95 : 55;
      reset  = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 99) < prob);
      req1   = ($urandom_range(0, 99) < prob);
      lock0  = ($urandom_range(0, 99) < 20);
      lock1  = ($urandom_range(0, 99) < 20);
      we0    = $urandom_range(0, 1) == 1;
      we1    = $urandom_range(0, 1) == 1;
      addr0  = $urandom; addr1 = $urandom;
      wdata0 = $urandom; wdata1 = $urandom;
      mask0  = 4'($urandom_range(0, 15));
      mask1  = 4'($urandom_range(0, 15));
      rndRdata = $urandom;
      @(negedge clk);
      checkRandom(n);
      modelStep();
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
